// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants for the timing generator and the renderers.
package vga_timing_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam int COORD_W       = 10;
    localparam logic SYNC_ACTIVE = 1'b0;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with synchronous reset to RST_VAL; DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int W = 1,
    parameter int DEPTH = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    if (DEPTH == 0) begin : g_pass
        logic unused;
        assign unused = ^{clk_i, rst_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign q_o = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered blank/sync decode, frame/line strobes
// and sync copies delayed to match the renderers' colour pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int SYNC_DELAY = 2
) (
    input  logic               vga_clk,
    input  logic               reset,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               hs_d,
    output logic               vs_d,
    output logic               blank_d,
    output logic               frame_start,
    output logic               line_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_ON  = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_OFF = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_ON  = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_OFF = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the coordinate range");
    end

    logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic blank_q, hs_q, vs_q, fs_q, ls_q;
    logic [2:0] dly;

    always_comb begin
        hc_d = (hc_q == H_LAST) ? '0 : hc_q + 1'b1;
        vc_d = (hc_q != H_LAST) ? vc_q : (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end

    // Reset parks on the last position of the frame so release starts a whole frame at (0,0).
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q    <= H_LAST;
            vc_q    <= V_LAST;
            blank_q <= 1'b0;
            hs_q    <= ~SYNC_ACTIVE;
            vs_q    <= ~SYNC_ACTIVE;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            blank_q <= (hc_d < H_VIS) && (vc_d < V_VIS);
            hs_q    <= (hc_d >= HS_ON && hc_d < HS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q    <= (vc_d >= VS_ON && vc_d < VS_OFF) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            fs_q    <= (hc_d == '0) && (vc_d == '0);
            ls_q    <= (hc_d == '0);
        end
    end

    sync_delay_line #(
        .W      (3),
        .DEPTH  (SYNC_DELAY),
        .RST_VAL({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0})
    ) u_sync_dly (
        .clk_i(vga_clk),
        .rst_i(reset),
        .d_i  ({hs_q, vs_q, blank_q}),
        .q_o  (dly)
    );

    assign {hs_d, vs_d, blank_d} = dly;
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance plus reduced-timing instances (SYNC_DELAY 2 and 0)
// checked every cycle against a queued model, with directed boundary checks.
module tb_vga_timing_gen;
    localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4, SHT = 80;
    localparam int SVV = 48, SVF = 2, SVS = 2, SVB = 4, SVT = 56;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic b, h, v, bd, hd, vd, fs, ls;
    } obs_t;
    typedef struct packed {obs_t d, s, z;} exp_t;

    logic vga_clk = 1'b0;
    logic reset = 1'b1;
    wire obs_t o_d, o_s, o_z;
    int n_cmp = 0, n_bad = 0;
    exp_t sb[$];

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_def (
        .vga_clk(vga_clk), .reset(reset), .DrawX(o_d.x), .DrawY(o_d.y), .blank(o_d.b),
        .hs(o_d.h), .vs(o_d.v), .hs_d(o_d.hd), .vs_d(o_d.vd), .blank_d(o_d.bd),
        .frame_start(o_d.fs), .line_start(o_d.ls)
    );
    vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                     .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                     .SYNC_DELAY(2)) u_sm (
        .vga_clk(vga_clk), .reset(reset), .DrawX(o_s.x), .DrawY(o_s.y), .blank(o_s.b),
        .hs(o_s.h), .vs(o_s.v), .hs_d(o_s.hd), .vs_d(o_s.vd), .blank_d(o_s.bd),
        .frame_start(o_s.fs), .line_start(o_s.ls)
    );
    vga_timing_gen #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                     .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                     .SYNC_DELAY(0)) u_z (
        .vga_clk(vga_clk), .reset(reset), .DrawX(o_z.x), .DrawY(o_z.y), .blank(o_z.b),
        .hs(o_z.h), .vs(o_z.v), .hs_d(o_z.hd), .vs_d(o_z.vd), .blank_d(o_z.bd),
        .frame_start(o_z.fs), .line_start(o_z.ls)
    );

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    function automatic obs_t dec(int hc, int vc, int hv, int hf, int hs, int vv, int vf, int vs,
                                 logic [2:0] dl);
        obs_t r;
        r.x  = 10'(hc);
        r.y  = 10'(vc);
        r.b  = (hc < hv) && (vc < vv);
        r.h  = !(hc >= hv + hf && hc < hv + hf + hs);
        r.v  = !(vc >= vv + vf && vc < vv + vf + vs);
        {r.hd, r.vd, r.bd} = dl;
        r.fs = (hc == 0) && (vc == 0);
        r.ls = (hc == 0);
        return r;
    endfunction

    int dh, dv, sh, sv;
    logic [2:0] dp1 = 3'b110, dp2 = 3'b110, sp1 = 3'b110, sp2 = 3'b110;
    obs_t ed, es;

    // Reference model: one expected entry per clock edge, queued for the negedge checker.
    always @(posedge vga_clk) begin
        exp_t e;
        if (reset) begin
            dh = 799; dv = 524; sh = SHT - 1; sv = SVT - 1;
            dp1 = 3'b110; dp2 = 3'b110; sp1 = 3'b110; sp2 = 3'b110;
        end else begin
            dp2 = dp1; dp1 = {ed.h, ed.v, ed.b};
            sp2 = sp1; sp1 = {es.h, es.v, es.b};
            dh = (dh == 799) ? 0 : dh + 1;
            if (dh == 0) dv = (dv == 524) ? 0 : dv + 1;
            sh = (sh == SHT - 1) ? 0 : sh + 1;
            if (sh == 0) sv = (sv == SVT - 1) ? 0 : sv + 1;
        end
        ed = dec(dh, dv, 640, 16, 96, 480, 10, 2, dp2);
        es = dec(sh, sv, SHV, SHF, SHS, SVV, SVF, SVS, sp2);
        e.d = ed;
        e.s = es;
        e.z = es;
        {e.z.hd, e.z.vd, e.z.bd} = {es.h, es.v, es.b};
        sb.push_back(e);
    end

    always @(negedge vga_clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_def", o_d, e.d);
            chk("sb_small", o_s, e.s);
            chk("sb_nodelay", o_z, e.z);
        end
    end

    int hrun = 0, vrun = 0;
    always @(negedge vga_clk) begin
        if (!o_s.h) hrun++;
        else if (hrun != 0) begin chk("hs_width", hrun, SHS); hrun = 0; end
        if (!o_s.v) vrun++;
        else if (vrun != 0) begin chk("vs_width", vrun, SVS * SHT); vrun = 0; end
    end

    task automatic wait_sm(int x, int y, int budget);
        int n = 0;
        while (!(o_s.x == 10'(x) && o_s.y == 10'(y)) && n < budget) begin
            @(negedge vga_clk);
            n++;
        end
        chk($sformatf("reach_%0d_%0d", x, y), n < budget, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int hl = 0, hfirst = -1, hlast = -1, bc = 0, lc = 0, b640 = 1, n, bad;
        reset = 1'b1;
        repeat (5) @(negedge vga_clk);
        chk("rst_pos", {o_d.x, o_d.y}, {10'd799, 10'd524});
        chk("rst_dec", {o_d.b, o_d.h, o_d.v, o_d.fs, o_d.ls, o_d.bd, o_d.hd, o_d.vd}, 8'b01100011);
        reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge vga_clk);
            if (i == 0) chk("first_pos", {o_d.x, o_d.y, o_d.b, o_d.fs}, {10'd0, 10'd0, 2'b11});
            if (i < 3) chk($sformatf("dly_%0d", i), {o_d.bd, o_d.hd, o_d.vd}, i < 2 ? 3'b011 : 3'b111);
            if (!o_d.h) begin
                hl++;
                if (hfirst < 0) hfirst = int'(o_d.x);
                hlast = int'(o_d.x);
            end
            bc += int'(o_d.b);
            lc += int'(o_d.ls);
            if (o_d.x == 10'd640) b640 = int'(o_d.b);
        end
        chk("hs_low_cnt", hl, 96);
        chk("hs_first", hfirst, 656);
        chk("hs_last", hlast, 751);
        chk("blank_cnt", bc, 640);
        chk("blank_640", b640, 0);
        chk("line_start_cnt", lc, 1);

        n = 0;
        while (!o_s.fs && n < 5000) begin @(negedge vga_clk); n++; end
        chk("fs_found", n < 5000, 1);
        n = 0;
        bad = 0;
        do begin
            @(negedge vga_clk);
            n++;
            if (o_s.y >= 10'(SVV) && o_s.b) bad++;
        end while (!o_s.fs && n < 5000);
        chk("fs_period", n, SHT * SVT);
        chk("vblank_blank", bad, 0);

        wait_sm(SHT - 1, SVV - 1, 5000);
        @(negedge vga_clk);
        chk("wrap_vis", {o_s.x, o_s.y, o_s.b}, {10'd0, 10'(SVV), 1'b0});
        wait_sm(SHT - 1, SVT - 1, 5000);
        @(negedge vga_clk);
        chk("wrap_frame", {o_s.x, o_s.y, o_s.b, o_s.fs}, {10'd0, 10'd0, 2'b11});

        wait_sm(30, 20, 5000);
        reset = 1'b1;
        @(negedge vga_clk);
        chk("midrst_pos", {o_s.x, o_s.y}, {10'(SHT - 1), 10'(SVT - 1)});
        chk("midrst_dec", {o_s.b, o_s.h, o_s.v, o_s.fs}, 4'b0110);
        reset = 1'b0;
        @(negedge vga_clk);
        chk("midrst_rel", {o_s.x, o_s.y, o_s.b, o_s.fs}, {10'd0, 10'd0, 2'b11});
        repeat (2 * SHT * SVT) @(negedge vga_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
